// File: rtl/ex_div_unit.sv
// Radix-2 restoring DIV/DIVU for EX: DATA_W+1 cycles accept-to-ready, 2 for divide-by-zero.
// Stalls IF/ID/EX until the result is ready. Optional DIV_EARLY_OUT_EN finishes in 1 cycle when |dividend| < |divisor|.
`default_nettype none

module ex_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic                  annul_i,
    output logic                  stallreq_o,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {S_FREE, S_BY_ZERO, S_ON, S_END} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     counter;
    logic [DATA_W-1:0] dq;        // dividend magnitude shifting out, quotient shifting in
    logic [DATA_W-1:0] dvs_r;
    logic [DATA_W-1:0] rem;
    logic              neg_q, neg_r;

    logic              accept, divisor_zero, last_iter;
    logic              dvd_neg, dvs_neg;
    logic [DATA_W-1:0] dvd_mag, dvs_mag;
    logic [DATA_W:0]   partial, diff;
    logic              qbit;
    logic [DATA_W-1:0] rem_nxt, q_nxt, q_fin, r_fin;
`ifdef DIV_EARLY_OUT_EN
    logic              early;
`endif

    assign accept       = (state == S_FREE) && start_i && !annul_i;
    assign divisor_zero = (divisor_i == '0);
    assign last_iter    = (counter == CW'(DATA_W - 1));
    assign dvd_neg      = signed_i & dividend_i[DATA_W-1];
    assign dvs_neg      = signed_i & divisor_i[DATA_W-1];
    assign dvd_mag      = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign dvs_mag      = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
`ifdef DIV_EARLY_OUT_EN
    assign early        = (dvd_mag < dvs_mag);
`endif

    // One restoring step: shift in the next dividend bit, try the subtraction.
    assign partial = {rem, dq[DATA_W-1]};
    assign diff    = partial - {1'b0, dvs_r};
    assign qbit    = ~diff[DATA_W];
    assign rem_nxt = qbit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
    assign q_nxt   = {dq[DATA_W-2:0], qbit};
    assign q_fin   = neg_q ? (~q_nxt + 1'b1) : q_nxt;
    assign r_fin   = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FREE: begin
                if (accept) begin
                    if (divisor_zero) begin
                        state_nxt = S_BY_ZERO;
                    end else begin
`ifdef DIV_EARLY_OUT_EN
                        state_nxt = early ? S_END : S_ON;
`else
                        state_nxt = S_ON;
`endif
                    end
                end
            end
            S_BY_ZERO: state_nxt = annul_i ? S_FREE : S_END;
            S_ON: begin
                if (annul_i) begin
                    state_nxt = S_FREE;
                end else if (last_iter) begin
                    state_nxt = S_END;
                end
            end
            S_END: state_nxt = (annul_i || !start_i) ? S_FREE : S_END;
            default: state_nxt = S_FREE;
        endcase
    end

    // The stall request is masked by reset so the pipeline is released immediately.
    always_comb begin
        stallreq_o = 1'b0;
        ready_o    = 1'b0;
        if (rst) begin
            case (state)
                S_FREE:    stallreq_o = start_i && !annul_i;
                S_BY_ZERO: stallreq_o = !annul_i;
                S_ON:      stallreq_o = !annul_i;
                S_END:     ready_o    = !annul_i;
                default:   stallreq_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter  <= '0;
            dq       <= '0;
            dvs_r    <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else if (accept) begin
            counter <= '0;
            rem     <= '0;
            dvs_r   <= dvs_mag;
            neg_q   <= dvd_neg ^ dvs_neg;
            neg_r   <= dvd_neg;
            // Divide-by-zero keeps the raw dividend as its remainder.
            dq      <= divisor_zero ? dividend_i : dvd_mag;
`ifdef DIV_EARLY_OUT_EN
            if (!divisor_zero && early) begin
                result_o <= {dividend_i, {DATA_W{1'b0}}};
            end
`endif
        end else if (state == S_ON && !annul_i) begin
            counter <= counter + CW'(1);
            rem     <= rem_nxt;
            dq      <= q_nxt;
            if (last_iter) begin
                result_o <= {r_fin, q_fin};
            end
        end else if (state == S_BY_ZERO && !annul_i) begin
            result_o <= {dq, {DATA_W{1'b1}}};
        end
    end

endmodule

`default_nettype wire
